imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the processor's instruction memory.
- Accepts a byte stream over a valid/ready handshake and packs each group of 4 bytes, MSB first, into one 32-bit instruction word.
- Writes each word to consecutive 8-bit addresses starting at 0, then checks a trailing XOR checksum byte.
- Holds the processor core in reset (cpu_hold) from reset until a load completes with a good checksum.

Parameters:
- ADDR_W, 8, instruction memory address width (matches the 8-bit pc).
- WORD_W, 32, instruction width; fixed at 4 bytes per word.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; sampled only in IDLE, DONE or ERR.
- len  input  9  number of words to load; valid range 1..256; sampled when start is accepted.
- byte_in  input  8  stream data.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts byte_in this cycle.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_addr  output  8  write address.
- mem_wdata  output  32  write data.
- busy  output  1  high in RECV, WRITE and CHK.
- done  output  1  load finished with a good checksum; held high.
- err  output  1  checksum mismatch or len==0; held high.
- cpu_hold  output  1  keeps the core in reset while high.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, cpu_hold=1.
  - Byte counter, word counter and checksum clear to 0.
- A handshake occurs on any clock edge where byte_valid and byte_ready are both 1. The producer may hold byte_valid high across cycles.
- IDLE / DONE / ERR, on start:
  - len==0 goes to ERR (err=1).
  - Any other len latches len, clears addr, byte counter and checksum, clears done and err, sets cpu_hold=1, and goes to RECV.
- start while busy is ignored.
- RECV:
  - byte_ready=1.
  - Each handshake shifts byte_in into the word register from the MSB side (first byte becomes wdata[31:24]) and XORs byte_in into the checksum.
  - The 4th handshake moves to WRITE on the next edge.
- WRITE (exactly one cycle):
  - byte_ready=0, mem_we=1, mem_addr=current address, mem_wdata=packed word.
  - Next edge: address increments and the word counter increments.
  - If word counter+1 == len, go to CHK; otherwise go to RECV.
- Latency: mem_we asserts the cycle after the 4th byte handshake.
- Address wrap: with len=256 the last write uses address 255. The address then wraps to 0 and is not used again.
- CHK:
  - byte_ready=1.
  - On handshake, if byte_in == checksum go to DONE; otherwise go to ERR.
  - The checksum covers data bytes only.
- DONE: done=1, cpu_hold=0, busy=0, byte_ready=0.
- ERR: err=1, cpu_hold=1, busy=0, byte_ready=0.
- byte_valid low stalls RECV or CHK indefinitely; no timeout.
- Bytes presented outside RECV/CHK are not accepted, because byte_ready=0.
- Asserting rst mid-load aborts immediately. Words already written stay in memory. cpu_hold returns to 1.
- mem_we is never high for more than one consecutive cycle.

Test Plan:
- Reset, then start with len=1 and bytes 0x12,0x34,0x56,0x78,0x08 (0x12^0x34^0x56^0x78=0x08) -> one mem_we at addr 0 with wdata 0x12345678; then done=1, cpu_hold=0, err=0.
- len=3, 12 data bytes plus correct checksum, byte_valid toggled every other cycle -> writes at addr 0,1,2 with correctly packed words; byte_ready=0 in each WRITE cycle; done=1.
- len=1, data 0xAABBCCDD, checksum byte 0x01 (expected 0x00) -> the word is still written at addr 0; then err=1, done=0, cpu_hold=1. A following start with a correct stream ends with done=1.
- start with len=0 -> err=1 on the next cycle, no mem_we, cpu_hold=1.
- len=256 -> the final write is at addr 255, then checksum, then done; 256 mem_we pulses total.
- Assert rst after 6 bytes of a len=2 load -> all outputs return to reset values asynchronously. A start pulse during an active load (before rst) is ignored and the address is unchanged.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: packs a byte stream MSB-first into 32-bit
// words, writes them to consecutive addresses, then checks a trailing XOR byte.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [8:0]        len,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHK, DONE, ERR} state_t;

  state_t            state, nxt;
  logic [8:0]        len_q, wcnt;
  logic [1:0]        bcnt;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] word;
  logic              can_start, go;

  assign can_start = (state == IDLE) || (state == DONE) || (state == ERR);
  assign go        = can_start && start && (len != 9'd0);
  assign mem_addr  = addr;
  assign mem_wdata = word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt        = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    cpu_hold   = 1'b1;
    case (state)
      RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid && bcnt == 2'd3) nxt = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
        nxt    = (wcnt + 9'd1 == len_q) ? CHK : RECV;
      end
      CHK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) nxt = (byte_in == csum) ? DONE : ERR;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ERR:     err = 1'b1;
      default: ;
    endcase
    // start is only honoured from the resting states
    if (can_start && start) nxt = (len == 9'd0) ? ERR : RECV;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q <= '0;
      wcnt  <= '0;
      bcnt  <= '0;
      csum  <= '0;
      addr  <= '0;
      word  <= '0;
    end else begin
      if (go) begin
        len_q <= len;
        wcnt  <= '0;
        bcnt  <= '0;
        csum  <= '0;
        addr  <= '0;
      end
      if (state == RECV && byte_valid) begin
        word <= {word[WORD_W-9:0], byte_in};
        csum <= csum ^ byte_in;
        bcnt <= bcnt + 2'd1;
      end
      // address wraps to 0 after the 256th word; it is never written again
      if (state == WRITE) begin
        addr <= addr + ADDR_W'(1);
        wcnt <= wcnt + 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load scenarios with random data and valid
// patterns, scored against words/checksum computed directly from the byte list.
module tb_imem_loader;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, byte_valid = 1'b0;
  logic [8:0]  len = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_ready, mem_we, busy, done, err, cpu_hold;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;

  imem_loader #(.ADDR_W(8), .WORD_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .err(err), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // write monitor
  logic [7:0]  wr_a[$];
  logic [31:0] wr_d[$];
  int          dbl = 0, rdy_bad = 0;
  logic        prev_we = 1'b0;
  always @(negedge clk) begin
    if (mem_we) begin
      wr_a.push_back(mem_addr);
      wr_d.push_back(mem_wdata);
      if (byte_ready) rdy_bad++;
      if (prev_we) dbl++;
    end
    prev_we = mem_we;
  end

  logic [7:0] dat[$];
  logic [7:0] stream[$];

  typedef struct {
    int len;
    int mode;      // 0 valid always, 1 toggle, 2 random
    bit bad;
    bit exp_done;
    bit exp_err;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start(input int l);
    @(negedge clk); start = 1'b1; len = l[8:0];
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_stream(input int mode);
    int cyc = 0;
    bit v;
    while (stream.size() > 0 && cyc < 20000) begin
      @(negedge clk); cyc++;
      v = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : ($urandom_range(0, 2) != 0);
      byte_valid = v;
      byte_in = v ? stream[0] : 8'($urandom);
      if (v && byte_ready) void'(stream.pop_front());
    end
    @(negedge clk); byte_valid = 1'b0;
    checks++;
    if (stream.size() != 0) begin
      errors++;
      $display("FAIL stream_timeout: %0d bytes left, expected 0", stream.size());
      stream.delete();
    end
  endtask

  task automatic fill(input int l);
    dat.delete();
    for (int i = 0; i < 4 * l; i++) dat.push_back(8'($urandom));
  endtask

  // csx: -1 correct checksum, -2 random wrong checksum, >=0 literal byte
  task automatic do_load(input string nm, input int l, input int mode, input int csx,
                         input bit exp_done, input bit exp_err);
    int base = wr_a.size();
    logic [7:0]  cs = 8'h00;
    logic [31:0] w;
    foreach (dat[i]) cs ^= dat[i];
    stream = dat;
    if (csx == -1)      stream.push_back(cs);
    else if (csx == -2) stream.push_back(cs ^ 8'($urandom_range(1, 255)));
    else                stream.push_back(csx[7:0]);
    pulse_start(l);
    send_stream(mode);
    chk({nm, "_nwrites"}, wr_a.size() - base, l);
    for (int i = 0; i < l && base + i < wr_a.size(); i++) begin
      w = {dat[4*i], dat[4*i+1], dat[4*i+2], dat[4*i+3]};
      if (wr_a[base+i] !== i[7:0] || wr_d[base+i] !== w) begin
        chk($sformatf("%s_addr%0d", nm, i), {24'h0, wr_a[base+i]}, i);
        chk($sformatf("%s_word%0d", nm, i), wr_d[base+i], w);
        break;
      end
    end
    chk({nm, "_done"}, done, exp_done);
    chk({nm, "_err"}, err, exp_err);
    chk({nm, "_cpu_hold"}, cpu_hold, !exp_done);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_we_back2back"}, dbl, 0);
    chk({nm, "_ready_in_write"}, rdy_bad, 0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_byte_ready"}, byte_ready, 0);
    chk({nm, "_mem_we"}, mem_we, 0);
    chk({nm, "_mem_addr"}, mem_addr, 0);
    chk({nm, "_mem_wdata"}, mem_wdata, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_cpu_hold"}, cpu_hold, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    vecs[0] = '{1,   0, 0, 1, 0};
    vecs[1] = '{3,   1, 0, 1, 0};
    vecs[2] = '{1,   0, 1, 0, 1};
    vecs[3] = '{2,   2, 0, 1, 0};
    vecs[4] = '{5,   2, 0, 1, 0};
    vecs[5] = '{4,   1, 1, 0, 1};
    vecs[6] = '{256, 2, 0, 1, 0};
    vecs[7] = '{7,   0, 0, 1, 0};

    #2 rst = 1'b1;
    #1 chk_reset_vals("reset");
    @(negedge clk); @(negedge clk); rst = 1'b0;

    // known-answer load
    dat = '{8'h12, 8'h34, 8'h56, 8'h78};
    do_load("kat1", 1, 0, 8'h08, 1, 0);

    // bad checksum still writes the word, then a clean reload recovers
    dat = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_load("badcs", 1, 0, 8'h01, 0, 1);
    fill(2);
    do_load("recover", 2, 1, -1, 1, 0);

    // len == 0 goes straight to ERR without writing
    base = wr_a.size();
    pulse_start(0);
    chk("len0_err", err, 1);
    chk("len0_done", done, 0);
    chk("len0_cpu_hold", cpu_hold, 1);
    chk("len0_busy", busy, 0);
    @(negedge clk);
    chk("len0_nwrites", wr_a.size() - base, 0);

    for (int k = 0; k < 8; k++) begin
      fill(vecs[k].len);
      do_load($sformatf("vec%0d", k), vecs[k].len, vecs[k].mode,
              vecs[k].bad ? -2 : -1, vecs[k].exp_done, vecs[k].exp_err);
    end

    // 6 bytes into a len=2 load, ignored start, then async reset
    fill(2);
    base = wr_a.size();
    stream = dat[0:5];
    pulse_start(2);
    send_stream(0);
    pulse_start(7);
    chk("abort_busy", busy, 1);
    chk("abort_ready", byte_ready, 1);
    chk("abort_addr", mem_addr, 1);
    chk("abort_nwrites", wr_a.size() - base, 1);
    if (wr_a.size() > base)
      chk("abort_word0", wr_d[base], {dat[0], dat[1], dat[2], dat[3]});
    #2 rst = 1'b1;
    #1 chk_reset_vals("abort_rst");
    @(negedge clk); rst = 1'b0;

    fill(3);
    do_load("post_rst", 3, 2, -1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
